// File: rtl/mac_pipeline_n.sv
// rtl/mac_pipeline_n.sv - three-stage N-channel unsigned multiply-accumulate
// Optional saturation with sticky overflow flag: define MAC_PIPELINE_SAT_EN.
module mac_pipeline_n #(
    parameter int W     = 10,
    parameter int N     = 2,
    parameter int OUT_W = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [N*W-1:0]     a,
    input  logic [N*W-1:0]     b,
    input  logic               acc_mode,
    input  logic               clr,
    output logic               out_valid,
    output logic [OUT_W-1:0]   out,
    output logic               ovf
);
    localparam int PROD_W = 2 * W;
    localparam int SUM_W  = PROD_W + $clog2(N);

    logic [N-1:0][PROD_W-1:0] p_d;
    logic [N-1:0][PROD_W-1:0] p_q;
    logic                     v1, m1;
    logic [SUM_W-1:0]         sum_d;
    logic [SUM_W-1:0]         sum_q;
    logic                     v2, m2;
    logic [OUT_W-1:0]         next_out;

    // Operands are widened before multiplying so the product keeps all 2W bits.
    always_comb begin
        p_d = '0;
        for (int i = 0; i < N; i++) begin
            p_d[i] = PROD_W'(a[i*W +: W]) * PROD_W'(b[i*W +: W]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q <= '0;
            v1  <= 1'b0;
            m1  <= 1'b0;
        end else begin
            p_q <= p_d;
            v1  <= in_valid;
            m1  <= acc_mode;
        end
    end

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < N; i++) begin
            sum_d = sum_d + SUM_W'(p_q[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
            v2    <= 1'b0;
            m2    <= 1'b0;
        end else begin
            sum_q <= sum_d;
            v2    <= v1;
            m2    <= m1;
        end
    end

`ifdef MAC_PIPELINE_SAT_EN
    localparam int EXT_W = ((OUT_W > SUM_W) ? OUT_W : SUM_W) + 1;

    logic [EXT_W-1:0] total;
    logic             over;
    logic             ovf_q;

    // A concurrent clr drops the old accumulator so the item starts fresh.
    always_comb begin
        total    = ((m2 && !clr) ? EXT_W'(out) : EXT_W'(0)) + EXT_W'(sum_q);
        over     = |total[EXT_W-1:OUT_W];
        next_out = over ? {OUT_W{1'b1}} : total[OUT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (v2) begin
            ovf_q <= (clr ? 1'b0 : ovf_q) | over;
        end else if (clr) begin
            ovf_q <= 1'b0;
        end
    end

    assign ovf = ovf_q;
`else
    always_comb begin
        next_out = ((m2 && !clr) ? out : '0) + OUT_W'(sum_q);
    end

    assign ovf = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= v2;
            if (v2) begin
                out <= next_out;
            end else if (clr) begin
                out <= '0;
            end
        end
    end
endmodule

// File: doc/mac_pipeline_n.md
Name: mac_pipeline_n

Overview:
Parametrised pipelined multiply-accumulate block. It computes the dot product of N unsigned operand pairs, sum(a[i]*b[i]), and optionally accumulates successive results. It supersedes the fixed two-pair product-sum pipeline with configurable width, channel count, a valid qualifier and an accumulate/clear mode. It sits in the datapath between operand registers and downstream result capture.

Parameters:
W, 10, operand width per channel (unsigned)
N, 2, number of operand pairs; valid range 1..16
OUT_W, 24, output/accumulator width; must be >= 2*W + clog2(N)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand set valid this cycle
a  input  N*W  packed operands; a[i] = a[i*W +: W]
b  input  N*W  packed operands; b[i] = b[i*W +: W]
acc_mode  input  1  sampled with in_valid; 1 = add the result to the accumulator, 0 = load the result
clr  input  1  synchronous accumulator clear
out_valid  output  1  out holds a new result this cycle
out  output  OUT_W  result / accumulator value
ovf  output  1  sticky overflow flag (see Optional Feature)

Behaviour:
- One clock; reset is asynchronous and active-low: rst_n=0 immediately clears all pipeline data, the valid and acc_mode shift bits, the accumulator, out (0), out_valid (0) and ovf (0).
- Three register stages; latency is 3 cycles:
  - S1: N products p[i] = a[i]*b[i], each 2W bits, registered. v1 <= in_valid; m1 <= acc_mode.
  - S2: sum of all p[i], 2W+clog2(N) bits, registered. v2 <= v1; m2 <= m1.
  - S3: accumulator/output update. out_valid <= v2.
- A set applied with in_valid=1 before edge k appears at out, with out_valid=1, after edge k+2 (third edge).
- Data registers in S1 and S2 load every cycle regardless of valid. Only S3 is gated.
- S3 update when v2=1:
  - m2=0 or clr=1: out <= zero-extended sum.
  - m2=1 and clr=0: out <= out + sum, computed modulo 2^OUT_W unless the macro is enabled.
- S3 when v2=0:
  - clr=1: out <= 0.
  - clr=0: out holds.
  - out_valid <= 0 in both cases.
- clr and a valid S3 item in the same cycle: the item starts a fresh accumulation. The result equals that item's sum, never 0.
- Back-to-back in_valid is fully supported: throughput is 1 set per cycle with no bubbles. A gap in in_valid produces a matching gap in out_valid.
- Reset mid-operation: in-flight items are discarded and no out_valid is produced for them.
- No backpressure: the consumer must capture out whenever out_valid=1.

Optional Feature:
- Macro: MAC_PIPELINE_SAT_EN.
- Defined: an accumulate whose true sum exceeds 2^OUT_W-1 sets out to all-ones (saturate) and sets ovf=1. ovf stays set until rst_n=0 or clr=1. Once saturated, further accumulation holds all-ones.
- Undefined: accumulation wraps modulo 2^OUT_W. ovf is tied to 0.

Test Plan:
1. Reset then single set, N=2, W=10: a=(3,1), b=(2,5), acc_mode=0, one-cycle in_valid -> 3 cycles later out_valid=1 for exactly 1 cycle, out=11; out holds 11 afterwards.
2. Back-to-back sets (3,1)x(2,5) then (5,3)x(5,3), acc_mode=0 -> out_valid high for 2 consecutive cycles with out=11 then out=34.
3. Accumulate: sets giving 11, 34, 16 with acc_mode=1 on all -> outputs 11, 45, 61. Assert clr alongside the next valid item (sum 16, acc_mode=1) -> out=16.
4. Reset mid-flight: launch 3 valid sets, pull rst_n low asynchronously between edges after the 2nd -> out=0, out_valid=0 immediately; no out_valid after release until new input.
5. Overflow with OUT_W=20, W=10, all operands 1023, acc_mode=1, 2 sets (each sum 2,093,058, which exceeds 2^20-1):
   - Without macro: out = 2093058 mod 2^20 = 1,044,482, then (4186116 mod 2^20) = 1,040,388; ovf=0.
   - With MAC_PIPELINE_SAT_EN: out = 1,048,575 on both outputs; ovf=1 until clr.
6. N=1 and N=4 elaborations: N=4 with a=(1,2,3,4), b=(4,3,2,1) -> out=20 after 3 cycles; N=1 with a=7, b=9 -> out=63.
